pipe_seg_reg: RTL and testbench

Parametrised pipeline segment register that replaces the fixed 32-bit pause/clear segment register between CPU stages. It adds a valid/ready handshake with a one-entry skid buffer (registered `in_ready`), a synchronous flush that inserts a bubble, a selectable bubble value, and a saturating stall-cycle counter for performance monitoring. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with `WIDTH` sized to that stage's bundle.

---
 rtl/pipe_seg_reg.sv | 103 ++++++++++
 tb/tb_pipe_seg_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_reg.sv
// Pipeline segment register: valid/ready handshake with a one-entry skid,
// synchronous flush to a bubble, and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no entry held; main = BUBBLE; accepting
// ST_BUSY  | main holds the only entry; accepting
// ST_FULL  | main holds the older entry, skid the newer; not accepting
module pipe_seg_reg #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             accept;
   logic             take;

   assign accept    = in_valid & in_ready;
   assign take      = out_valid & out_ready;
   assign out_data  = main_q;
   assign occupancy = 2'(state);

   // in_ready and out_valid are flops updated alongside the state, so no
   // combinational path exists from out_ready back to in_ready.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= ST_EMPTY;
         main_q    <= BUBBLE;
         skid_q    <= BUBBLE;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q    <= in_data;
                  state     <= ST_BUSY;
                  out_valid <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (accept && take) begin
                  main_q <= in_data;
               end else if (accept) begin
                  skid_q   <= in_data;
                  state    <= ST_FULL;
                  in_ready <= 1'b0;
               end else if (take) begin
                  main_q    <= BUBBLE;
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (take) begin
                  main_q   <= skid_q;
                  skid_q   <= BUBBLE;
                  state    <= ST_BUSY;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               main_q    <= BUBBLE;
               skid_q    <= BUBBLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   // Flush deliberately leaves the counter alone; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Bench for pipe_seg_reg: two instances (zero bubble with 3-bit counter,
// all-ones bubble with 16-bit counter) share stimulus and a queue model.
module tb_pipe_seg_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        out_ready = 1'b0;

   logic        in_ready0, out_valid0, in_ready1, out_valid1;
   logic [31:0] out_data0, out_data1;
   logic [1:0]  occupancy0, occupancy1;
   logic [2:0]  stall_cnt0;
   logic [15:0] stall_cnt1;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: FIFO of held entries (front is what out_data shows).
   logic [31:0] mq[$];
   int unsigned m_stall = 0;

   always #5 clk = ~clk;

   pipe_seg_reg #(.WIDTH(32), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .occupancy(occupancy0), .stall_cnt(stall_cnt0)
   );

   pipe_seg_reg #(.WIDTH(32), .BUBBLE(32'hFFFF_FFFF), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .occupancy(occupancy1), .stall_cnt(stall_cnt1)
   );

   task automatic step();
      bit ov, tk, ac;
      @(posedge clk);
      ov = mq.size() > 0;
      tk = ov && out_ready;
      ac = in_valid && (mq.size() < 2);
      if (rst) begin
         mq.delete();
         m_stall = 0;
      end else begin
         if (ov && !out_ready) m_stall++;
         if (flush) mq.delete();
         else begin
            if (tk) void'(mq.pop_front());
            if (ac) mq.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
      step(); step();
      n_chk++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid0); end
      n_chk++; if (out_data0 !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %0h expected 0", out_data0); end
      n_chk++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready0); end
      n_chk++; if (occupancy0 !== 2'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy0); end
      n_chk++; if (stall_cnt0 !== 3'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt0); end
      n_chk++; if (out_data1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_bubble: got %0h expected ffffffff", out_data1); end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_data = 32'(i);
         step();
         n_chk++; if (out_valid0 !== 1'b1 || out_data0 !== 32'(i)) begin n_err++; $display("FAIL stream_data: got v=%0b d=%0h expected v=1 d=%0h", out_valid0, out_data0, i); end
         n_chk++; if (occupancy0 !== 2'd1 || in_ready0 !== 1'b1) begin n_err++; $display("FAIL stream_occ: got occ=%0d rdy=%0b expected occ=1 rdy=1", occupancy0, in_ready0); end
      end
      in_valid = 1'b0;
      step();
      n_chk++; if (occupancy0 !== 2'd0 || out_valid0 !== 1'b0) begin n_err++; $display("FAIL stream_drain: got occ=%0d v=%0b expected occ=0 v=0", occupancy0, out_valid0); end
      n_chk++; if (out_data1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL drain_bubble: got %0h expected ffffffff", out_data1); end
   endtask

   task automatic test_skid();
      logic [31:0] seen[$];
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA;
      step();
      out_ready = 1'b0; in_data = 32'hB;
      step();
      in_data = 32'hC;
      step();
      n_chk++; if (occupancy0 !== 2'd2 || in_ready0 !== 1'b0) begin n_err++; $display("FAIL skid_full: got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy0, in_ready0); end
      n_chk++; if (out_data0 !== 32'hA) begin n_err++; $display("FAIL skid_hold: got %0h expected a", out_data0); end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid0) seen.push_back(out_data0);
         step();
         if (i == 1) in_valid = 1'b0;
      end
      n_chk++; if (seen.size() != 3) begin n_err++; $display("FAIL skid_count: got %0d expected 3", seen.size()); end
      else begin
         n_chk++; if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin n_err++; $display("FAIL skid_order: got %0h %0h %0h expected a b c", seen[0], seen[1], seen[2]); end
      end
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      step();
      in_data = 32'hB;
      step();
      n_chk++; if (occupancy0 !== 2'd2) begin n_err++; $display("FAIL flush_prefill: got %0d expected 2", occupancy0); end
      flush = 1'b1; in_data = 32'hC;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_chk++; if (occupancy0 !== 2'd0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin n_err++; $display("FAIL flush_state: got occ=%0d v=%0b rdy=%0b expected 0 0 1", occupancy0, out_valid0, in_ready0); end
      n_chk++; if (out_data0 !== 32'h0 || out_data1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL flush_bubble: got %0h %0h expected 0 ffffffff", out_data0, out_data1); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL flush_no_c: got v=%0b d=%0h expected v=0", out_valid0, out_data0); end
      end
   endtask

   task automatic test_stall_sat();
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         n_chk++; if (stall_cnt0 !== 3'((i > 7) ? 7 : i) || stall_cnt1 !== 16'(i)) begin n_err++; $display("FAIL stall_count: got %0d/%0d expected %0d/%0d", stall_cnt0, stall_cnt1, (i > 7) ? 7 : i, i); end
      end
      flush = 1'b1; step(); flush = 1'b0;
      n_chk++; if (stall_cnt0 !== 3'd7 || stall_cnt1 !== 16'd11) begin n_err++; $display("FAIL stall_flush: got %0d/%0d expected 7/11", stall_cnt0, stall_cnt1); end
      rst = 1'b1; step(); rst = 1'b0;
      n_chk++; if (stall_cnt0 !== 3'd0 || stall_cnt1 !== 16'd0) begin n_err++; $display("FAIL stall_rst: got %0d/%0d expected 0/0", stall_cnt0, stall_cnt1); end
   endtask

   task automatic test_random();
      logic [31:0] e_d0, e_d1;
      logic        e_ov, e_ir;
      logic [1:0]  e_occ;
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = $urandom;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 32) == 0;
         rst       = ($urandom % 128) == 0;
         step();
         e_ov  = mq.size() > 0;
         e_ir  = mq.size() < 2;
         e_occ = 2'(mq.size());
         e_d0  = e_ov ? mq[0] : 32'h0;
         e_d1  = e_ov ? mq[0] : 32'hFFFF_FFFF;
         n_chk++; if (out_valid0 !== e_ov || in_ready0 !== e_ir || occupancy0 !== e_occ) begin n_err++; $display("FAIL rand_ctl0 cyc %0d: got v=%0b r=%0b o=%0d expected v=%0b r=%0b o=%0d", i, out_valid0, in_ready0, occupancy0, e_ov, e_ir, e_occ); end
         n_chk++; if (out_valid1 !== e_ov || in_ready1 !== e_ir || occupancy1 !== e_occ) begin n_err++; $display("FAIL rand_ctl1 cyc %0d: got v=%0b r=%0b o=%0d expected v=%0b r=%0b o=%0d", i, out_valid1, in_ready1, occupancy1, e_ov, e_ir, e_occ); end
         n_chk++; if (out_data0 !== e_d0 || out_data1 !== e_d1) begin n_err++; $display("FAIL rand_data cyc %0d: got %0h/%0h expected %0h/%0h", i, out_data0, out_data1, e_d0, e_d1); end
         n_chk++; if (stall_cnt0 !== 3'((m_stall > 7) ? 7 : m_stall) || stall_cnt1 !== 16'(m_stall)) begin n_err++; $display("FAIL rand_stall cyc %0d: got %0d/%0d expected %0d", i, stall_cnt0, stall_cnt1, m_stall); end
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_skid();
      test_flush_full();
      test_stall_sat();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
